// File: rtl/registrador_id_ex.sv
// ID/EX pipeline register for the 16-bit ULA. Holds decoded fields and presents
// forwarded operands to the execute stage; supports stall (hold) and flush (bubble).
module registrador_id_ex #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [WIDTH-1:0]  id_rs_data,
  input  logic [WIDTH-1:0]  id_rt_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic              id_usa_imm,
  input  logic [2:0]        id_ula_control,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              fwd_mem_we,
  input  logic [ADDR_W-1:0] fwd_mem_addr,
  input  logic [WIDTH-1:0]  fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [ADDR_W-1:0] fwd_wb_addr,
  input  logic [WIDTH-1:0]  fwd_wb_data,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_a,
  output logic [WIDTH-1:0]  ex_b,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [2:0]        ex_ula_control,
  output logic [ADDR_W-1:0] ex_rd_addr,
  output logic              ex_reg_write
);

  logic              valid_q;
  logic [ADDR_W-1:0] rs_addr_q;
  logic [ADDR_W-1:0] rt_addr_q;
  logic [WIDTH-1:0]  rs_val_q;
  logic [WIDTH-1:0]  rt_val_q;
  logic [WIDTH-1:0]  imm_q;
  logic              usa_imm_q;
  logic [2:0]        ula_control_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              reg_write_q;

  logic              rs_mem_hit;
  logic              rs_wb_hit;
  logic              rt_mem_hit;
  logic              rt_wb_hit;
  logic [WIDTH-1:0]  fwd_rs;
  logic [WIDTH-1:0]  fwd_rt;

  // Register 0 is hardwired zero, so a write reported to it must never be forwarded.
  always_comb begin
    rs_mem_hit = fwd_mem_we && (fwd_mem_addr == rs_addr_q) && (rs_addr_q != '0);
    rs_wb_hit  = fwd_wb_we  && (fwd_wb_addr  == rs_addr_q) && (rs_addr_q != '0);
    rt_mem_hit = fwd_mem_we && (fwd_mem_addr == rt_addr_q) && (rt_addr_q != '0);
    rt_wb_hit  = fwd_wb_we  && (fwd_wb_addr  == rt_addr_q) && (rt_addr_q != '0);

    fwd_rs = rs_val_q;
    if (rs_mem_hit)     fwd_rs = fwd_mem_data;
    else if (rs_wb_hit) fwd_rs = fwd_wb_data;

    fwd_rt = rt_val_q;
    if (rt_mem_hit)     fwd_rt = fwd_mem_data;
    else if (rt_wb_hit) fwd_rt = fwd_wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_q       <= 1'b0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rs_val_q      <= '0;
      rt_val_q      <= '0;
      imm_q         <= '0;
      usa_imm_q     <= 1'b0;
      ula_control_q <= 3'b000;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
    end else if (stall) begin
      // Absorb producers that retire while we wait, so their value is not lost.
      rs_val_q <= fwd_rs;
      rt_val_q <= fwd_rt;
    end else begin
      valid_q       <= id_valid;
      rs_addr_q     <= id_rs_addr;
      rt_addr_q     <= id_rt_addr;
      rs_val_q      <= id_rs_data;
      rt_val_q      <= id_rt_data;
      imm_q         <= id_imm;
      usa_imm_q     <= id_usa_imm;
      ula_control_q <= id_ula_control;
      rd_addr_q     <= id_rd_addr;
      reg_write_q   <= id_reg_write & id_valid;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_a           = fwd_rs;
  assign ex_b           = usa_imm_q ? imm_q : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_ula_control = ula_control_q;
  assign ex_rd_addr     = rd_addr_q;
  assign ex_reg_write   = reg_write_q;

endmodule

// File: tb/tb_registrador_id_ex.sv
// Self-checking bench for registrador_id_ex: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_registrador_id_ex;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid, id_usa_imm, id_reg_write;
  logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_ula_control;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        fwd_mem_we, fwd_wb_we;
  logic [2:0]  fwd_mem_addr, fwd_wb_addr;
  logic [15:0] fwd_mem_data, fwd_wb_data;
  logic        ex_valid, ex_reg_write;
  logic [15:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_ula_control, ex_rd_addr;

  int checks = 0;
  int failures = 0;

  registrador_id_ex #(.WIDTH(16), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_usa_imm(id_usa_imm), .id_ula_control(id_ula_control),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_ula_control(ex_ula_control), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  always #5 clock = ~clock;

  // Model state: what the EX slot holds, as the instruction-level view.
  logic        m_valid, m_ui, m_rw;
  logic [2:0]  m_rs, m_rt, m_rd, m_ctrl;
  logic [15:0] m_rsv, m_rtv, m_imm;

  function automatic logic [15:0] operand(input logic [2:0] a, input logic [15:0] v);
    if (a == 3'd0) return v;
    if (fwd_mem_we && fwd_mem_addr == a) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_addr == a) return fwd_wb_data;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] a, t;
    a = operand(m_rs, m_rsv);
    t = operand(m_rt, m_rtv);
    cmp("model_valid", {15'd0, ex_valid}, {15'd0, m_valid});
    cmp("model_a", ex_a, a);
    cmp("model_b", ex_b, m_ui ? m_imm : t);
    cmp("model_store", ex_store_data, t);
    cmp("model_ctrl", {13'd0, ex_ula_control}, {13'd0, m_ctrl});
    cmp("model_rd", {13'd0, ex_rd_addr}, {13'd0, m_rd});
    cmp("model_rw", {15'd0, ex_reg_write}, {15'd0, m_rw});
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic do_cycle();
    logic [15:0] a, t;
    #1;
    check_model();
    a = operand(m_rs, m_rsv);
    t = operand(m_rt, m_rtv);
    @(posedge clock);
    if (reset || flush) begin
      {m_valid, m_ui, m_rw} = '0;
      {m_rs, m_rt, m_rd, m_ctrl} = '0;
      {m_rsv, m_rtv, m_imm} = '0;
    end else if (stall) begin
      m_rsv = a;
      m_rtv = t;
    end else begin
      m_valid = id_valid; m_rs = id_rs_addr; m_rt = id_rt_addr;
      m_rsv = id_rs_data; m_rtv = id_rt_data; m_imm = id_imm;
      m_ui = id_usa_imm; m_ctrl = id_ula_control; m_rd = id_rd_addr;
      m_rw = id_reg_write & id_valid;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0;
    id_valid = 0; id_usa_imm = 0; id_reg_write = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_ula_control = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    fwd_mem_we = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
    fwd_wb_we = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
  endtask

  task automatic load(input logic [2:0] rs, input logic [15:0] rsd,
                      input logic [2:0] rt, input logic [15:0] rtd,
                      input logic ui, input logic [15:0] imm,
                      input logic [2:0] ctrl, input logic [2:0] rd, input logic rw);
    idle_inputs();
    id_valid = 1; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_usa_imm = ui; id_imm = imm; id_ula_control = ctrl; id_rd_addr = rd; id_reg_write = rw;
    do_cycle();
  endtask

  initial begin
    idle_inputs();
    // Reset with busy-looking decode inputs.
    reset = 1; id_valid = 1; id_reg_write = 1; id_rs_addr = 3; id_rs_data = 16'hDEAD;
    id_rt_data = 16'hBEEF; id_ula_control = 3'b101; id_rd_addr = 6;
    @(posedge clock);
    {m_valid, m_ui, m_rw} = '0; {m_rs, m_rt, m_rd, m_ctrl} = '0; {m_rsv, m_rtv, m_imm} = '0;
    @(negedge clock);
    do_cycle();
    reset = 0; id_valid = 0; id_reg_write = 0;
    #1;
    cmp("reset_valid", {15'd0, ex_valid}, 16'd0);
    cmp("reset_rw", {15'd0, ex_reg_write}, 16'd0);
    cmp("reset_ctrl", {13'd0, ex_ula_control}, 16'd0);
    cmp("reset_a", ex_a, 16'd0);
    cmp("reset_b", ex_b, 16'd0);
    do_cycle();

    // Plain load.
    load(3'd2, 16'h0005, 3'd3, 16'h0007, 1'b0, 16'h0000, 3'b001, 3'd4, 1'b1);
    idle_inputs(); stall = 1;
    #1;
    cmp("load_a", ex_a, 16'h0005);
    cmp("load_b", ex_b, 16'h0007);
    cmp("load_ctrl", {13'd0, ex_ula_control}, 16'h0001);
    cmp("load_rd", {13'd0, ex_rd_addr}, 16'h0004);
    cmp("load_rw", {15'd0, ex_reg_write}, 16'h0001);

    // Forward priority on stored rs=2.
    fwd_mem_we = 1; fwd_mem_addr = 2; fwd_mem_data = 16'h1111;
    fwd_wb_we = 1; fwd_wb_addr = 2; fwd_wb_data = 16'h2222;
    #1 cmp("fwd_mem_first", ex_a, 16'h1111);
    fwd_mem_we = 0;
    #1 cmp("fwd_wb", ex_a, 16'h2222);
    stall = 0; fwd_wb_we = 0;
    do_cycle();

    // rs=0 is never forwarded.
    load(3'd0, 16'h0033, 3'd1, 16'h0044, 1'b0, 16'h0, 3'b010, 3'd1, 1'b1);
    idle_inputs(); stall = 1;
    fwd_mem_we = 1; fwd_mem_addr = 0; fwd_mem_data = 16'h1111;
    fwd_wb_we = 1; fwd_wb_addr = 0; fwd_wb_data = 16'h2222;
    #1 cmp("zero_no_fwd", ex_a, 16'h0033);
    do_cycle();

    // Immediate selects b; store data still sees forwarded rt.
    load(3'd1, 16'h0009, 3'd3, 16'h1234, 1'b1, 16'h00F0, 3'b000, 3'd5, 1'b1);
    idle_inputs(); stall = 1;
    fwd_mem_we = 1; fwd_mem_addr = 3; fwd_mem_data = 16'hAAAA;
    #1;
    cmp("imm_b", ex_b, 16'h00F0);
    cmp("imm_store", ex_store_data, 16'hAAAA);
    do_cycle();

    // Stall refresh: wb pulse in the first stalled cycle must persist.
    load(3'd5, 16'h0001, 3'd6, 16'h0002, 1'b0, 16'h0, 3'b011, 3'd7, 1'b1);
    idle_inputs(); stall = 1; fwd_wb_we = 1; fwd_wb_addr = 5; fwd_wb_data = 16'h0BEE;
    #1 cmp("stall_c1_a", ex_a, 16'h0BEE);
    do_cycle();
    fwd_wb_we = 0;
    #1 cmp("stall_c2_a", ex_a, 16'h0BEE);
    do_cycle();
    #1 cmp("stall_c3_a", ex_a, 16'h0BEE);
    do_cycle();
    stall = 0;
    #1;
    cmp("release_a", ex_a, 16'h0BEE);
    cmp("release_rd", {13'd0, ex_rd_addr}, 16'h0007);
    cmp("release_ctrl", {13'd0, ex_ula_control}, 16'h0003);
    do_cycle();

    // Flush beats stall.
    load(3'd1, 16'h0001, 3'd2, 16'h0002, 1'b0, 16'h0, 3'b100, 3'd3, 1'b1);
    idle_inputs(); flush = 1; stall = 1;
    do_cycle();
    flush = 0; stall = 0;
    #1;
    cmp("flush_valid", {15'd0, ex_valid}, 16'd0);
    cmp("flush_rw", {15'd0, ex_reg_write}, 16'd0);
    // Invalid decode slot never writes.
    load(3'd1, 16'h0001, 3'd2, 16'h0002, 1'b0, 16'h0, 3'b100, 3'd3, 1'b1);
    id_valid = 0; id_reg_write = 1;
    do_cycle();
    #1 cmp("invalid_rw", {15'd0, ex_reg_write}, 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = $urandom_range(0, 1); id_reg_write = $urandom_range(0, 1);
      id_usa_imm = $urandom_range(0, 1);
      id_rs_addr = 3'($urandom_range(0, 3)); id_rt_addr = 3'($urandom_range(0, 3));
      id_rd_addr = 3'($urandom); id_ula_control = 3'($urandom);
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
      fwd_mem_we = $urandom_range(0, 1); fwd_mem_addr = 3'($urandom_range(0, 3));
      fwd_mem_data = 16'($urandom);
      fwd_wb_we = $urandom_range(0, 1); fwd_wb_addr = 3'($urandom_range(0, 3));
      fwd_wb_data = 16'($urandom);
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
